// File: rtl/fp_add_arbiter_if.sv
// Bundles the requester-side and adder-side handshake signals of fp_add_arbiter.
// The arbiter uses the slave modport; the environment (clients plus adder) uses master.
interface fp_add_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_stb;
  logic [NUM_REQ-1:0]    req_ack;
  logic [31:0]           rsp_z;
  logic [NUM_REQ-1:0]    rsp_stb;
  logic [NUM_REQ-1:0]    rsp_ack;
  logic [31:0]           add_a;
  logic                  add_a_stb;
  logic                  add_a_ack;
  logic [31:0]           add_b;
  logic                  add_b_stb;
  logic                  add_b_ack;
  logic [31:0]           add_z;
  logic                  add_z_stb;
  logic                  add_z_ack;

  modport slave (
    input  req_a, req_b, req_stb, rsp_ack, add_a_ack, add_b_ack, add_z, add_z_stb,
    output req_ack, rsp_z, rsp_stb, add_a, add_a_stb, add_b, add_b_stb, add_z_ack
  );

  modport master (
    output req_a, req_b, req_stb, rsp_ack, add_a_ack, add_b_ack, add_z, add_z_stb,
    input  req_ack, rsp_z, rsp_stb, add_a, add_a_stb, add_b, add_b_stb, add_z_ack
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Shares one strobe/ack single-precision adder among NUM_REQ requesters, one op in flight.
// Round-robin by default; define FP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module fp_add_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input logic             clk,
  input logic             rst,
  fp_add_arbiter_if.slave bus
);
  localparam int unsigned SCAN_W = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RETURN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   grant;
  logic [SCAN_W-1:0]  scan;
  logic               any_req;
  logic [NUM_REQ-1:0] req_ack;
  logic [NUM_REQ-1:0] rsp_stb;
  logic [31:0]        rsp_z;
  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic               add_a_stb;
  logic               add_b_stb;
  logic               add_z_ack;

  // First requesting index at or after rr_ptr; the wrap is explicit so non-power-of-two counts stay in range.
  always_comb begin
    any_req = 1'b0;
    grant   = '0;
    scan    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + SCAN_W'(k);
      if (scan >= SCAN_W'(NUM_REQ)) scan = scan - SCAN_W'(NUM_REQ);
      if (!any_req && bus.req_stb[scan[IDX_W-1:0]]) begin
        any_req = 1'b1;
        grant   = scan[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      req_ack   <= '0;
      rsp_stb   <= '0;
      rsp_z     <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
      add_z_ack <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant;
            add_a     <= bus.req_a[{grant, 5'd0} +: 32];
            add_b     <= bus.req_b[{grant, 5'd0} +: 32];
            req_ack   <= NUM_REQ'(1) << grant;
            add_a_stb <= 1'b1;
            state     <= SEND_A;
          end
        end
        SEND_A: begin
          if (add_a_stb && bus.add_a_ack) begin
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b1;
            state     <= SEND_B;
          end
        end
        SEND_B: begin
          if (add_b_stb && bus.add_b_ack) begin
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b1;
            state     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (bus.add_z_stb && add_z_ack) begin
            rsp_z     <= bus.add_z;
            add_z_ack <= 1'b0;
            rsp_stb   <= NUM_REQ'(1) << owner;
            state     <= RETURN;
          end
        end
        RETURN: begin
          // Adder stays idle until the owner consumes the result.
          if (bus.rsp_ack[owner]) begin
            rsp_stb <= '0;
`ifdef FP_ARB_FIXED_PRIO_EN
            rr_ptr  <= '0;
`else
            rr_ptr  <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`endif
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ack   = req_ack;
  assign bus.rsp_stb   = rsp_stb;
  assign bus.rsp_z     = rsp_z;
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.add_a_stb = add_a_stb;
  assign bus.add_b_stb = add_b_stb;
  assign bus.add_z_ack = add_z_ack;
endmodule
